// File: rtl/ysyx_24080014_axil_rd_slave.sv
`default_nettype none
// =============================================================================
// ysyx_24080014_axil_rd_slave : AXI4-Lite read responder over a preloadable word memory.
// Option YSYX_24080014_AXIL_RAND_LAT_EN: per-request latency from an 8-bit LFSR. Rev 1.0
// =============================================================================
module ysyx_24080014_axil_rd_slave #(
   parameter logic [31:0] BASE       = 32'h8000_0000,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        arvalid,
   output logic        arready,
   input  logic [31:0] araddr,
   output logic        rvalid,
   input  logic        rready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);
   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state, state_nx;
   logic [31:0] mem [DEPTH];
   logic [31:0] addr_q;
   logic [3:0]  cnt;
   logic [3:0]  lat;
   logic        rdy_en;
   logic        ar_hs;
   logic [31:0] rd_addr, rd_diff, ld_diff;
   logic        rd_ok, ld_ok;

   // The first response can be registered on the handshake edge itself, so
   // the address comes straight from the bus while still in IDLE.
   assign rd_addr = (state == IDLE) ? araddr : addr_q;
   assign rd_diff = rd_addr - BASE;
   assign ld_diff = ld_addr - BASE;
   assign rd_ok   = (rd_addr >= BASE) && ((rd_diff >> (DEPTH_LOG2 + 2)) == 32'd0)
                    && (rd_addr[1:0] == 2'b00);
   assign ld_ok   = (ld_addr >= BASE) && ((ld_diff >> (DEPTH_LOG2 + 2)) == 32'd0)
                    && (ld_addr[1:0] == 2'b00);

`ifdef YSYX_24080014_AXIL_RAND_LAT_EN
   logic [7:0] lfsr;
   always_ff @(posedge clk) begin
      if (rst) lfsr <= 8'hA5;
      else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign lat = 4'd1 + {1'b0, lfsr[2:0]};
`else
   assign lat = 4'(LATENCY);
`endif

   assign arready = rdy_en && (state == IDLE);
   assign rvalid  = (state == RESP);
   assign ar_hs   = arvalid && arready;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (ar_hs) state_nx = (lat == 4'd1) ? RESP : WAIT;
         WAIT:    if (cnt == 4'd1) state_nx = RESP;
         RESP:    if (rready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         rdy_en <= 1'b0;
         addr_q <= 32'd0;
         cnt    <= 4'd0;
         rdata  <= 32'd0;
         rresp  <= OKAY;
      end else begin
         state  <= state_nx;
         rdy_en <= 1'b1;
         if (ar_hs) begin
            addr_q <= araddr;
            cnt    <= lat - 4'd1;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if ((state != RESP) && (state_nx == RESP)) begin
            if (rd_ok) begin
               rdata <= mem[rd_diff[DEPTH_LOG2+1:2]];
               rresp <= OKAY;
            end else begin
               rdata <= 32'd0;
               rresp <= SLVERR;
            end
         end
      end
   end

   // Contents survive reset; a same-edge preload is seen only by later reads.
   always_ff @(posedge clk) begin
      if (ld_en && ld_ok) mem[ld_diff[DEPTH_LOG2+1:2]] <= ld_data;
   end
endmodule
`default_nettype wire
